master_slave_sampler_mc: RTL and testbench
==========================================

Name: master_slave_sampler_mc

Overview:
- Multi-channel, parametrised successor of the single-channel section_a/section_b master-slave test block.
- Visits NUM_CH slave input channels round-robin through a three-phase state machine:
  - sample a value when its sync flag is high;
  - transform the value according to MODE;
  - publish it on the matching slave output with a one-cycle valid pulse.
- Adds a per-channel sync-timeout with sticky error flags, so a silent channel cannot stall the others.
- Used as a generated-RTL regression target and as a reusable sampler in the test fabric.

Parameters:
- NUM_CH, 4, number of channels (1..16).
- DATA_W, 32, data width per channel.
- TIMEOUT, 8, SECTION_A wait cycles before a channel is skipped; 0 disables the timeout.
- MODE, 1, transform: 0 = pass-through, 1 = increment with wrap, 2 = saturating increment.

Ports:
- clk  input  1  clock, all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  allows SECTION_A to sample or count; has no effect in SECTION_B or SECTION_C.
- s_in  input  NUM_CH*DATA_W  channel data; channel k occupies bits [k*DATA_W +: DATA_W].
- s_in_sync  input  NUM_CH  per-channel sync flag; a value is taken only while its flag is high.
- clr_err  input  1  synchronous clear of all timeout_err bits.
- s_out  output  NUM_CH*DATA_W  per-channel published value; each slice holds its value until rewritten.
- s_out_valid  output  NUM_CH  one-cycle pulse marking the slice just written.
- timeout_err  output  NUM_CH  sticky per-channel timeout flags.
- phase  output  2  current state: 0 = SECTION_A, 1 = SECTION_B, 2 = SECTION_C.
- ch_ptr  output  clog2(NUM_CH), minimum 1  channel currently being served.

Behaviour:
- Reset (async, rst=1) forces:
  - phase=SECTION_A, ch_ptr=0;
  - internal val=0, wait_cnt=0;
  - s_out all 0, s_out_valid 0, timeout_err 0.
- SECTION_A (sample):
  - enable=0: hold all state; wait_cnt frozen.
  - enable=1 and s_in_sync[ch_ptr]=1: val <= slice ch_ptr of s_in; wait_cnt <= 0; go to SECTION_B.
  - enable=1 and sync low with TIMEOUT>0:
    - if wait_cnt == TIMEOUT-1: set timeout_err[ch_ptr]; wait_cnt <= 0; ch_ptr advances (wraps NUM_CH-1 -> 0); stay in SECTION_A.
    - otherwise: wait_cnt++.
  - TIMEOUT=0: wait indefinitely.
- SECTION_B (transform), always exactly one cycle, then SECTION_C:
  - MODE 0: val unchanged.
  - MODE 1: val <= val+1 modulo 2^DATA_W.
  - MODE 2: val <= val+1, except val stays at all-ones if already all-ones.
- SECTION_C (publish), exactly one cycle:
  - s_out slice ch_ptr <= val; other slices unchanged.
  - s_out_valid[ch_ptr] is 1 during the following cycle only.
  - ch_ptr advances with wrap; go to SECTION_A.
- s_out_valid is registered and at most one bit is high in any cycle.
- Latency: sync accepted at edge E0 -> s_out updated at E0+2 -> valid visible in the cycle after E0+2. Sustained throughput is one sample per 3 cycles.
- s_in or s_in_sync changes during SECTION_B/C are ignored; only the value latched in SECTION_A is published.
- clr_err=1 clears all timeout_err bits at the next edge. If a timeout sets a bit on the same edge, that bit ends set (set wins).
- A channel that timed out keeps its previous s_out value and receives no valid pulse.
- Reset asserted mid-operation aborts any in-flight sample; nothing is published; every output returns to its reset value immediately.
- NUM_CH=1: ch_ptr stays 0; the timeout only re-arms the same channel.

Test Plan:
- Reset, then s_in_sync=4'b0001 with ch0 data=0x10 (MODE=1) -> after 3 edges s_out[31:0]=0x11, s_out_valid=4'b0001 for exactly 1 cycle, ch_ptr=1.
- All sync high, ch0..3 data = 5,6,7,8 -> s_out slices = 6,7,8,9 published in order ch0..ch3 every 3 cycles; ch_ptr wraps back to 0.
- ch1 sync held low, TIMEOUT=8 -> after 8 SECTION_A cycles on ch1, timeout_err=4'b0010, ch_ptr=2, s_out slice 1 unchanged, no valid pulse.
- Saturation: MODE=2, data=0xFFFFFFFF -> output 0xFFFFFFFF. Wrap: MODE=1, same data -> output 0x00000000.
- enable=0 for 20 cycles in SECTION_A with sync low -> no timeout, wait_cnt frozen. Then clr_err asserted on the same edge as a timeout -> that error bit remains 1.
- rst pulsed while in SECTION_B -> no valid pulse; phase=0, ch_ptr=0, all outputs 0 immediately.

Source files
------------

// File: rtl/master_slave_sampler_mc.sv
// Purpose : round-robin multi-channel sampler; sample on sync, transform by MODE, publish with one-cycle valid.
// Latency : sync accepted at edge E0 -> s_out slice written at E0+2, s_out_valid high the cycle after E0+2.
// Backpressure: none downstream; a silent channel is skipped after TIMEOUT enabled wait cycles (sticky error).
module master_slave_sampler_mc #(
    parameter int NUM_CH  = 4,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 8,
    parameter int MODE    = 1,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [NUM_CH*DATA_W-1:0] s_in,
    input  logic [NUM_CH-1:0]        s_in_sync,
    input  logic                     clr_err,
    output logic [NUM_CH*DATA_W-1:0] s_out,
    output logic [NUM_CH-1:0]        s_out_valid,
    output logic [NUM_CH-1:0]        timeout_err,
    output logic [1:0]               phase,
    output logic [CH_W-1:0]          ch_ptr
);

    typedef enum logic [1:0] {
        SEC_A = 2'd0,
        SEC_B = 2'd1,
        SEC_C = 2'd2
    } state_t;

    // Wait counter only needs to reach TIMEOUT-1; keep it at least one bit wide.
    localparam int              WC_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int              WC_LIM  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(WC_LIM);
    localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM_CH - 1);

    state_t                  state_q, state_d;
    logic [CH_W-1:0]         ch_q, ch_d, ch_nxt;
    logic [DATA_W-1:0]       val_q, val_d;
    logic [WC_W-1:0]         wcnt_q, wcnt_d;
    logic [DATA_W-1:0]       sout_q [NUM_CH];
    logic [DATA_W-1:0]       sout_d [NUM_CH];
    logic [DATA_W-1:0]       s_in_arr [NUM_CH];
    logic [NUM_CH-1:0]       vld_q, vld_d;
    logic [NUM_CH-1:0]       err_q, err_d;

    // Split the flat input bus into per-channel slices; pack the published slices back out.
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        assign s_in_arr[k]                 = s_in[k*DATA_W +: DATA_W];
        assign s_out[k*DATA_W +: DATA_W]   = sout_q[k];
    end

    // Pointer advance with wrap; with a single channel this stays at zero.
    assign ch_nxt = (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;

    // Next-state logic for the sample/transform/publish sequence, timeout and error flags.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        val_d   = val_q;
        wcnt_d  = wcnt_q;
        sout_d  = sout_q;
        vld_d   = '0;
        // Clear first so a timeout on the same edge re-sets its bit (set wins).
        err_d   = clr_err ? '0 : err_q;
        case (state_q)
            SEC_A: begin
                if (enable) begin
                    if (s_in_sync[ch_q]) begin
                        val_d   = s_in_arr[ch_q];
                        wcnt_d  = '0;
                        state_d = SEC_B;
                    end else if (TIMEOUT > 0) begin
                        if (wcnt_q == WC_LAST) begin
                            err_d[ch_q] = 1'b1;
                            wcnt_d      = '0;
                            ch_d        = ch_nxt;
                        end else begin
                            wcnt_d = wcnt_q + 1'b1;
                        end
                    end
                end
            end
            SEC_B: begin
                if (MODE == 1) begin
                    val_d = val_q + 1'b1;
                end else if (MODE == 2) begin
                    if (val_q != '1) begin
                        val_d = val_q + 1'b1;
                    end
                end
                state_d = SEC_C;
            end
            SEC_C: begin
                sout_d[ch_q] = val_q;
                vld_d[ch_q]  = 1'b1;
                ch_d         = ch_nxt;
                state_d      = SEC_A;
            end
            default: state_d = SEC_A;
        endcase
    end

    // State register; reset aborts any in-flight sample and clears every output immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SEC_A;
            ch_q    <= '0;
            val_q   <= '0;
            wcnt_q  <= '0;
            vld_q   <= '0;
            err_q   <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                sout_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            val_q   <= val_d;
            wcnt_q  <= wcnt_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
            sout_q  <= sout_d;
        end
    end

    assign s_out_valid = vld_q;
    assign timeout_err = err_q;
    assign phase       = state_q;
    assign ch_ptr      = ch_q;

endmodule

// File: tb/tb_master_slave_sampler_mc.sv
// Purpose : directed bench for master_slave_sampler_mc, wrap (MODE 1) and saturating (MODE 2) instances side by side.
// Latency : expected publications are queued when sync is driven and retired when a valid pulse appears.
// Backpressure: none; all waits are fixed cycle counts.
module tb_master_slave_sampler_mc;

    localparam int NCH = 4;
    localparam int DW  = 32;

    typedef struct packed {
        logic [1:0]    ch;
        logic [DW-1:0] v;
    } ent_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable;
    logic             clr_err;
    logic [NCH*DW-1:0] s_in;
    logic [NCH-1:0]   s_in_sync;

    logic [NCH*DW-1:0] s_out1, s_out2;
    logic [NCH-1:0]   vld1, vld2, err1, err2;
    logic [1:0]       phase1, phase2;
    logic [1:0]       ptr1, ptr2;

    int errors = 0;
    int checks = 0;

    ent_t q1[$];
    ent_t q2[$];
    logic [NCH*DW-1:0] m1, m2;

    master_slave_sampler_mc #(.NUM_CH(NCH), .DATA_W(DW), .TIMEOUT(8), .MODE(1)) dut1 (
        .clk(clk), .rst(rst), .enable(enable), .s_in(s_in), .s_in_sync(s_in_sync),
        .clr_err(clr_err), .s_out(s_out1), .s_out_valid(vld1), .timeout_err(err1),
        .phase(phase1), .ch_ptr(ptr1)
    );

    master_slave_sampler_mc #(.NUM_CH(NCH), .DATA_W(DW), .TIMEOUT(8), .MODE(2)) dut2 (
        .clk(clk), .rst(rst), .enable(enable), .s_in(s_in), .s_in_sync(s_in_sync),
        .clr_err(clr_err), .s_out(s_out2), .s_out_valid(vld2), .timeout_err(err2),
        .phase(phase2), .ch_ptr(ptr2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] f_wrap(input logic [DW-1:0] v);
        return v + 1'b1;
    endfunction

    function automatic logic [DW-1:0] f_sat(input logic [DW-1:0] v);
        return (v == {DW{1'b1}}) ? v : v + 1'b1;
    endfunction

    task automatic push(input logic [1:0] ch, input logic [DW-1:0] v);
        q1.push_back({ch, f_wrap(v)});
        q2.push_back({ch, f_sat(v)});
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard: every valid pulse must retire the oldest queued publication of that instance.
    always @(negedge clk) begin : mon
        ent_t       e;
        logic [3:0] oh;
        if (rst === 1'b0) begin
            if (vld1 !== 4'b0) begin
                if (q1.size() == 0) begin
                    chk("d1_unexpected_valid", 128'(vld1), 128'(0));
                end else begin
                    e  = q1.pop_front();
                    oh = 4'b0001 << e.ch;
                    m1[e.ch*DW +: DW] = e.v;
                    chk("d1_valid_onehot", 128'(vld1), 128'(oh));
                    chk("d1_s_out", s_out1, m1);
                end
            end
            if (vld2 !== 4'b0) begin
                if (q2.size() == 0) begin
                    chk("d2_unexpected_valid", 128'(vld2), 128'(0));
                end else begin
                    e  = q2.pop_front();
                    oh = 4'b0001 << e.ch;
                    m2[e.ch*DW +: DW] = e.v;
                    chk("d2_valid_onehot", 128'(vld2), 128'(oh));
                    chk("d2_s_out", s_out2, m2);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; enable = 1'b0; clr_err = 1'b0; s_in = '0; s_in_sync = '0;
        m1 = '0; m2 = '0;
        tick(2);
        chk("rst_phase", 128'(phase1), 128'(0));
        chk("rst_ch_ptr", 128'(ptr1), 128'(0));
        chk("rst_s_out", s_out1, 128'(0));
        chk("rst_valid", 128'(vld1), 128'(0));
        chk("rst_err", 128'(err1), 128'(0));

        // Single sample on ch0: 0x10 -> 0x11 three edges later.
        rst = 1'b0; enable = 1'b1;
        s_in[31:0] = 32'h10; s_in_sync = 4'b0001; push(2'd0, 32'h10);
        tick(1);
        s_in_sync = 4'b0; s_in = '0;
        chk("t1_phase_b", 128'(phase1), 128'(1));
        tick(2);
        chk("t1_s_out0", 128'(s_out1[31:0]), 128'(32'h11));
        chk("t1_valid", 128'(vld1), 128'(4'b0001));
        chk("t1_ch_ptr", 128'(ptr1), 128'(1));
        tick(1);
        chk("t1_pulse_len", 128'(vld1), 128'(0));

        // Fresh start, then all channels synced: 5,6,7,8 -> 6,7,8,9 in order.
        rst = 1'b1; q1.delete(); q2.delete(); m1 = '0; m2 = '0;
        tick(1);
        rst = 1'b0;
        s_in = {32'd8, 32'd7, 32'd6, 32'd5}; s_in_sync = 4'hF;
        push(2'd0, 32'd5); push(2'd1, 32'd6); push(2'd2, 32'd7); push(2'd3, 32'd8);
        tick(11);
        // ch3 is in publish phase: its new input must be ignored; ch0 gets its next sample.
        s_in = {32'hDEAD, 32'd7, 32'd6, 32'h20}; s_in_sync = 4'b0001; push(2'd0, 32'h20);
        tick(1);
        chk("t2_wrap_ptr", 128'(ptr1), 128'(0));
        chk("t2_phase_a", 128'(phase1), 128'(0));
        chk("t2_s_out_all", s_out1, {32'd9, 32'd8, 32'd7, 32'd6});
        chk("t2_last_valid", 128'(vld1), 128'(4'b1000));
        tick(1);
        s_in_sync = 4'b0;
        tick(2);
        chk("t2_ch0_again", 128'(s_out1[31:0]), 128'(32'h21));
        chk("t3_start_ptr", 128'(ptr1), 128'(1));

        // ch1 silent: timeout on the 8th waiting edge.
        tick(7);
        chk("t3_no_early_err", 128'(err1), 128'(0));
        chk("t3_no_early_ptr", 128'(ptr1), 128'(1));
        tick(1);
        chk("t3_err", 128'(err1), 128'(4'b0010));
        chk("t3_ptr", 128'(ptr1), 128'(2));
        chk("t3_no_valid", 128'(vld1), 128'(0));
        chk("t3_slice1_kept", 128'(s_out1[63:32]), 128'(32'd7));

        // ch2: 3 counted cycles, 20 frozen, 4 more, then timeout together with clr_err.
        tick(3);
        enable = 1'b0;
        tick(20);
        chk("t5_frozen_err", 128'(err1), 128'(4'b0010));
        chk("t5_frozen_ptr", 128'(ptr1), 128'(2));
        enable = 1'b1;
        tick(4);
        chk("t5_resume_err", 128'(err1), 128'(4'b0010));
        chk("t5_resume_ptr", 128'(ptr1), 128'(2));
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        chk("t5_set_wins_d1", 128'(err1), 128'(4'b0100));
        chk("t5_set_wins_d2", 128'(err2), 128'(4'b0100));
        chk("t5_ptr", 128'(ptr1), 128'(3));

        // All-ones on ch3: wraps to 0 in MODE 1, saturates in MODE 2.
        s_in[127:96] = 32'hFFFF_FFFF; s_in_sync = 4'b1000; push(2'd3, 32'hFFFF_FFFF);
        tick(1);
        s_in_sync = 4'b0;
        tick(2);
        chk("t4_wrap", 128'(s_out1[127:96]), 128'(32'h0));
        chk("t4_sat", 128'(s_out2[127:96]), 128'(32'hFFFF_FFFF));
        chk("t4_ptr", 128'(ptr1), 128'(0));

        // Reset while the ch0 sample is in the transform phase.
        s_in[31:0] = 32'h33; s_in_sync = 4'b0001;
        tick(1);
        s_in_sync = 4'b0;
        chk("t6_in_b", 128'(phase1), 128'(1));
        rst = 1'b1;
        #1;
        m1 = '0; m2 = '0;
        chk("t6_phase", 128'(phase1), 128'(0));
        chk("t6_ptr", 128'(ptr1), 128'(0));
        chk("t6_s_out", s_out1, 128'(0));
        chk("t6_valid", 128'(vld1), 128'(0));
        chk("t6_err", 128'(err1), 128'(0));
        tick(3);
        rst = 1'b0;
        tick(3);
        chk("t6_no_publish", 128'(vld1), 128'(0));
        chk("t6_s_out_after", s_out1, 128'(0));
        chk("queue1_drained", 128'(q1.size()), 128'(0));
        chk("queue2_drained", 128'(q2.size()), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
